// File: rtl/mnist_pixel_loader.sv
// Binarising frame loader: collects a raster of pixels into a NUM_PIXELS-bit image,
// launches the forward-pass engine and holds the image until done or watchdog expiry.
module mnist_pixel_loader #(
  parameter int NUM_PIXELS = 784,
  parameter int PIX_W      = 8,
  parameter int THRESH     = 128,
  parameter int TIMEOUT    = 20000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [PIX_W-1:0]      pix_data,
  input  logic                  pix_last,
  output logic [NUM_PIXELS-1:0] image_bits,
  output logic                  fp_start,
  input  logic                  fp_done,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  fp_timeout,
  output logic [15:0]           frame_count
);

  localparam int CNT_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam logic [PIX_W-1:0] THR      = PIX_W'(THRESH);

  typedef enum logic [1:0] {
    S_FILL,
    S_DROP,
    S_LAUNCH,
    S_WAIT_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic [NUM_PIXELS-1:0]   image_q, image_d;
  logic [15:0]             frame_count_q, frame_count_d;
  logic                    pix_ready_q, pix_ready_d;
  logic                    busy_q, busy_d;
  logic                    fp_start_q, fp_start_d;
  logic                    frame_err_q, frame_err_d;
  logic                    fp_timeout_q, fp_timeout_d;
  logic                    xfer;

  assign xfer = pix_valid & pix_ready_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wd_d          = wd_q;
    image_d       = image_q;
    frame_count_d = frame_count_q;
    frame_err_d   = 1'b0;
    fp_timeout_d  = 1'b0;

    unique case (state_q)
      S_FILL: begin
        if (xfer) begin
          image_d[cnt_q] = (pix_data >= THR);
          if (pix_last) begin
            cnt_d = '0;
            if (cnt_q == LAST_IDX) begin
              state_d = S_LAUNCH;
              wd_d    = '0;
            end else begin
              frame_err_d = 1'b1;
            end
          end else if (cnt_q == LAST_IDX) begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
            state_d     = S_DROP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_DROP: begin
        if (xfer && pix_last) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
      end

      S_LAUNCH: begin
        // Watchdog counts from the fp_start cycle, so expiry lands TIMEOUT cycles after fp_start.
        state_d = S_WAIT_DONE;
        if (TIMEOUT != 0) begin
          wd_d = wd_q + 1'b1;
        end
      end

      S_WAIT_DONE: begin
        if (fp_done) begin
          frame_count_d = frame_count_q + 16'd1;
          state_d       = S_FILL;
        end else if ((TIMEOUT != 0) && (wd_q >= WD_LIMIT)) begin
          fp_timeout_d = 1'b1;
          state_d      = S_FILL;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + 1'b1;
        end
      end

      default: begin
        state_d = S_FILL;
        cnt_d   = '0;
      end
    endcase

    // Handshake and status outputs are registered images of the next state.
    pix_ready_d = (state_d == S_FILL) || (state_d == S_DROP);
    busy_d      = (state_d != S_FILL);
    fp_start_d  = (state_d == S_LAUNCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FILL;
      cnt_q         <= '0;
      wd_q          <= '0;
      image_q       <= '0;
      frame_count_q <= '0;
      pix_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      fp_start_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      fp_timeout_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wd_q          <= wd_d;
      image_q       <= image_d;
      frame_count_q <= frame_count_d;
      pix_ready_q   <= pix_ready_d;
      busy_q        <= busy_d;
      fp_start_q    <= fp_start_d;
      frame_err_q   <= frame_err_d;
      fp_timeout_q  <= fp_timeout_d;
    end
  end

  assign pix_ready   = pix_ready_q;
  assign image_bits  = image_q;
  assign fp_start    = fp_start_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign fp_timeout  = fp_timeout_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_mnist_pixel_loader.sv
// Directed bench for mnist_pixel_loader: expected images are queued as frames are sent
// and checked against image_bits when fp_start fires.
module tb_mnist_pixel_loader;

  localparam int NP = 784;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [7:0]    pix_data = 8'd0;
  logic          pix_last = 1'b0;
  logic [NP-1:0] image_bits;
  logic          fp_start;
  logic          fp_done = 1'b0;
  logic          busy;
  logic          frame_err;
  logic          fp_timeout;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  mnist_pixel_loader #(
    .NUM_PIXELS(NP),
    .PIX_W(8),
    .THRESH(128),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data(pix_data),
    .pix_last(pix_last),
    .image_bits(image_bits),
    .fp_start(fp_start),
    .fp_done(fp_done),
    .busy(busy),
    .frame_err(frame_err),
    .fp_timeout(fp_timeout),
    .frame_count(frame_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int   start_cnt = 0, err_cnt = 0, to_cnt = 0, stretch_cnt = 0, overlap_cnt = 0;
  logic prev_err = 1'b0, prev_to = 1'b0, prev_start = 1'b0;

  always @(negedge clk) begin
    if (fp_start) start_cnt <= start_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if (fp_timeout) to_cnt <= to_cnt + 1;
    if ((frame_err && prev_err) || (fp_timeout && prev_to) || (fp_start && prev_start))
      stretch_cnt <= stretch_cnt + 1;
    if (frame_err && fp_timeout) overlap_cnt <= overlap_cnt + 1;
    prev_err   <= frame_err;
    prev_to    <= fp_timeout;
    prev_start <= fp_start;
  end

  logic [NP-1:0] sb_q[$];
  logic [NP-1:0] cur_exp;
  logic [7:0]    fr[$];
  int            exp_fc = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_img(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
    int bad;
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      bad = -1;
      for (int k = NP - 1; k >= 0; k--) if (obs[k] !== exp[k]) bad = k;
      $error("FAIL %s: first differing bit %0d observed %b expected %b", tag, bad,
             obs[bad], exp[bad]);
    end
  endtask

  function automatic logic [NP-1:0] model_img(input logic [7:0] f[$]);
    logic [NP-1:0] r;
    r = '0;
    for (int k = 0; k < NP; k++) r[k] = (f[k] >= 8'd128);
    return r;
  endfunction

  task automatic fill_random(input int n);
    fr.delete();
    for (int k = 0; k < n; k++) fr.push_back(8'($urandom_range(255)));
  endtask

  // Drives fr[] as a frame; last_at marks pix_last, abort_at stops early (-1 = never),
  // ready_from asserts pix_ready on every beat from that index, err_at checks frame_err there.
  task automatic send_frame(input int last_at, input int gap_pct, input int abort_at,
                            input int ready_from, input int err_at);
    int guard;
    for (int i = 0; i < fr.size(); i++) begin
      tick();
      if (i == abort_at) break;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        pix_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      pix_valid = 1'b1;
      pix_data  = fr[i];
      pix_last  = (i == last_at);
      if (i == err_at) chk("long_frame_err_pulse", frame_err, 1);
      if (ready_from >= 0 && i >= ready_from) chk("ready_in_drop", pix_ready, 1);
      guard = 0;
      while (!pix_ready && guard < 50) begin
        tick();
        guard++;
      end
      if (guard == 50) chk("ready_wait_timeout", pix_ready, 1);
    end
    tick();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic wait_start();
    int guard;
    guard = 0;
    while (!fp_start && guard < 20) begin
      tick();
      guard++;
    end
    chk("fp_start_seen", fp_start, 1);
    chk("scoreboard_nonempty", (sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      cur_exp = sb_q.pop_front();
      chk_img("image_at_start", image_bits, cur_exp);
    end
  endtask

  task automatic finish_frame(input int delay);
    repeat (delay) tick();
    chk_img("image_held", image_bits, cur_exp);
    fp_done = 1'b1;
    tick();
    fp_done = 1'b0;
    exp_fc++;
    chk("busy_after_done", busy, 0);
    chk("frame_count", frame_count, 64'(exp_fc));
  endtask

  int s0, e0, t;

  initial begin
    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fp_start", fp_start, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_fp_timeout", fp_timeout, 0);
    chk("rst_frame_count", frame_count, 0);
    chk_img("rst_image", image_bits, '0);

    // 1: alternating 0x00/0xFF
    fr.delete();
    for (int k = 0; k < NP; k++) fr.push_back((k % 2 == 1) ? 8'hFF : 8'h00);
    sb_q.push_back(model_img(fr));
    s0 = start_cnt;
    send_frame(NP - 1, 0, -1, -1, -1);
    chk("busy_in_launch", busy, 1);
    wait_start();
    chk("alt_bit0", image_bits[0], 0);
    chk("alt_bit1", image_bits[1], 1);
    chk("alt_one_start", start_cnt, 64'(s0 + 1));
    finish_frame(5);

    // 2: threshold boundaries, fp_done during the launch cycle is ignored
    fill_random(NP);
    fr[0] = 8'd127; fr[1] = 8'd128; fr[2] = 8'd255; fr[3] = 8'd0;
    sb_q.push_back(model_img(fr));
    send_frame(NP - 1, 0, -1, -1, -1);
    wait_start();
    chk("thr_127", image_bits[0], 0);
    chk("thr_128", image_bits[1], 1);
    chk("thr_255", image_bits[2], 1);
    chk("thr_0", image_bits[3], 0);
    fp_done = 1'b1;
    tick();
    fp_done = 1'b0;
    tick();
    chk("done_in_launch_ignored", busy, 1);
    finish_frame(2);

    // 3: short frame, with stray fp_done while filling
    s0 = start_cnt;
    e0 = err_cnt;
    fill_random(100);
    fp_done = 1'b1;
    send_frame(99, 0, -1, -1, -1);
    chk("short_err_pulse", frame_err, 1);
    fp_done = 1'b0;
    tick();
    tick();
    chk("short_err_count", err_cnt, 64'(e0 + 1));
    chk("short_no_start", start_cnt, 64'(s0));
    chk("short_count_same", frame_count, 64'(exp_fc));
    fill_random(NP);
    sb_q.push_back(model_img(fr));
    send_frame(NP - 1, 0, -1, -1, -1);
    wait_start();
    finish_frame(3);

    // 4: 800-pixel frame, tail dropped
    s0 = start_cnt;
    e0 = err_cnt;
    fill_random(800);
    send_frame(799, 0, -1, 0, NP);
    tick();
    chk("long_err_count", err_cnt, 64'(e0 + 1));
    chk("long_no_start", start_cnt, 64'(s0));
    chk("long_back_to_fill", busy, 0);
    fill_random(NP);
    sb_q.push_back(model_img(fr));
    send_frame(NP - 1, 0, -1, -1, -1);
    wait_start();
    finish_frame(1);

    // 5: watchdog expiry
    fill_random(NP);
    sb_q.push_back(model_img(fr));
    send_frame(NP - 1, 0, -1, -1, -1);
    wait_start();
    t = 0;
    while (!fp_timeout && t < 40) begin
      tick();
      t++;
    end
    chk("timeout_delay", t, TO);
    chk("timeout_busy", busy, 0);
    chk("timeout_ready", pix_ready, 1);
    chk("timeout_count_same", frame_count, 64'(exp_fc));
    chk("timeout_pulses", to_cnt, 1);
    tick();
    chk("timeout_one_cycle", fp_timeout, 0);

    // 6: gappy frame aborted by reset at pixel 400, then a clean gappy frame
    s0 = start_cnt;
    fill_random(NP);
    send_frame(NP - 1, 30, 400, -1, -1);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    exp_fc = 0;
    chk("abort_ready", pix_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_count_cleared", frame_count, 0);
    chk("abort_no_start", start_cnt, 64'(s0));
    chk_img("abort_image_cleared", image_bits, '0);
    fill_random(NP);
    sb_q.push_back(model_img(fr));
    send_frame(NP - 1, 30, -1, -1, -1);
    wait_start();
    finish_frame(4);

    chk("no_pulse_stretch", stretch_cnt, 0);
    chk("err_timeout_exclusive", overlap_cnt, 0);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
